// File: rtl/rsa_mul_pkg.sv
// Shared RSA datapath constants: multiplier/divider sizing and FSM state encodings.
package rsa_mul_pkg;

  localparam int unsigned RSA_MUL_WIDTH = 128;
  localparam int unsigned RSA_MUL_CNT_W = 8;

  localparam int unsigned RSA_DIV_WIDTH = 128;
  localparam int unsigned RSA_DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } rsa_state_e;

endpackage

// File: rtl/rsa_mul_addsub.sv
// Carry-lookahead adder/subtractor (add_sub=0 adds, 1 subtracts) built from 4-bit lookahead groups.
module AddSubCLA129Bits #(
  parameter int unsigned W = 129
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add_sub,
  output logic [W-1:0] s,
  output logic         c_out
);

  localparam int unsigned NG = (W + 3) / 4;

  always_comb begin
    logic        cg;
    logic        cb;
    logic        gg;
    logic        gp;
    logic        bi;
    logic        g;
    logic        p;
    int unsigned idx;
    s  = '0;
    cg = add_sub;
    cb = 1'b0;
    gg = 1'b0;
    gp = 1'b1;
    bi = 1'b0;
    g  = 1'b0;
    p  = 1'b0;
    idx = 0;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      gg = 1'b0;
      gp = 1'b1;
      cb = cg;
      for (int unsigned j = 0; j < 4; j++) begin
        idx = gi * 4 + j;
        if (idx < W) begin
          bi = b[idx] ^ add_sub;
          g  = a[idx] & bi;
          p  = a[idx] ^ bi;
          s[idx] = p ^ cb;
          cb = g | (p & cb);
          gg = g | (p & gg);
          gp = gp & p;
        end
      end
      // group carry-out skips the in-group ripple chain
      cg = gg | (gp & cg);
    end
    c_out = cg;
  end

endmodule

// File: rtl/rsa_mul.sv
// Sequential shift-and-add multiplier: one partial product per clock, WIDTH clocks per multiply.
module rsa_mul
  import rsa_mul_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_MUL_WIDTH,
  parameter int unsigned CNT_W = RSA_MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand_a,
  input  logic [WIDTH-1:0]     multiplier_b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_out,
  output logic [CNT_W-1:0]     count_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  rsa_state_e       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_c;

  always_comb begin
    addend = lo[0] ? m : '0;
  end

  AddSubCLA129Bits #(
    .W(WIDTH)
  ) u_adder (
    .a      (hi),
    .b      (addend),
    .add_sub(1'b0),
    .s      (sum_lo),
    .c_out  (sum_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            m     <= multiplicand_a;
            lo    <= multiplier_b;
            hi    <= '0;
            count <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_RUN: begin
          // {carry, sum} shifted right one: sum LSB moves into the top of lo
          hi    <= {sum_c, sum_lo[WIDTH-1:1]};
          lo    <= {sum_lo[0], lo[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    product   = {hi, lo};
    state_out = state;
    count_out = count;
  end

endmodule

// File: tb/tb_rsa_mul.sv
// Scoreboard bench for rsa_mul: directed operands, expected products queued at issue, checked on done.
module tb_rsa_mul;

  localparam int unsigned W = 128;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [2*W-1:0]   product;
  logic             busy;
  logic             done;
  logic [1:0]       state_out;
  logic [7:0]       count_out;

  always #5 clk = ~clk;

  rsa_mul #(
    .WIDTH(W),
    .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .multiplicand_a(a),
    .multiplier_b  (b),
    .product       (product),
    .busy          (busy),
    .done          (done),
    .state_out     (state_out),
    .count_out     (count_out)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    string          name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   lat = 0;
  int   overlap = 0;
  logic done_q = 1'b0;
  logic busy_q = 1'b0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      lat    = 0;
      done_q = 1'b0;
      busy_q = 1'b0;
    end else begin
      if (busy && done) overlap++;
      if (busy) lat = busy_q ? lat + 1 : 1;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", product);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_product"}, product, mon_e.prod);
          chk({mon_e.name, "_latency"}, lat, W);
        end
      end
      done_q = done;
      busy_q = busy;
    end
  end

  task automatic mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic [2*W-1:0] ep, input string nm);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sb.push_back('{prod: ep, name: nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (done) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=done_low required=done_high", nm);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_product"}, product, '0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_state"}, state_out, 0);
    chk({nm, "_count"}, count_out, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 reset_n = 1'b1;

    mul(128'd3, 128'd5, 256'd15, "a3b5");
    chk("a3b5_busy_after_accept", busy, 1);
    chk("a3b5_state_run", state_out, 2'b01);
    chk("a3b5_count_start", count_out, 0);
    wait_done("a3b5");
    repeat (5) @(negedge clk);
    chk("done_hold_flag", done, 1);
    chk("done_hold_product", product, 256'd15);
    chk("done_hold_state", state_out, 2'b10);

    mul('1, '1, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1}, "all_ones");
    wait_done("all_ones");

    mul(128'd0, 128'h1234, 256'd0, "zero_a");
    wait_done("zero_a");

    mul(128'd1, 128'hDEADBEEF, 256'hDEADBEEF, "one_a");
    wait_done("one_a");

    mul(128'd1000, 128'd1000, 256'd1000000, "inject");
    repeat (39) @(negedge clk);
    chk("inject_count", count_out, 39);
    start = 1'b1;
    a     = 128'd5;
    b     = 128'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done("inject");

    mul(128'd9, 128'd9, 256'd81, "aborted");
    repeat (59) @(negedge clk);
    #1 reset_n = 1'b0;
    void'(sb.pop_back());
    #1 check_zero("reset_mid_run");
    @(negedge clk);
    #1 reset_n = 1'b1;

    mul(128'd7, 128'd6, 256'd42, "after_reset");
    wait_done("after_reset");

    start = 1'b1;
    a     = 128'd10;
    b     = 128'd10;
    sb.push_back('{prod: 256'd100, name: "back_to_back"});
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    start = 1'b0;
    wait_done("back_to_back");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_done_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
